mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Y86 memory stage: the consumer of the execute stage's icode/valA/valE outputs.
- Decodes icode to a data-memory read or write, runs a req/ack transaction on the data bus, captures valM, and presents a result bundle to writeback.
- Stalls upstream via a ready/valid handshake while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width (valE/valA low bits used).
- MEM_BYTES, 4096, size of data memory in bytes; used only by the optional address check.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low (sampled on rising clk)
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept a bundle
- icode_i  in  8  instruction code (`BYTE)
- valA_i  in  32  operand A; store data, pop/ret address, or return address for CALL
- valE_i  in  32  ALU result; address for RMMOVL/MRMOVL/PUSHL/CALL
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  write data
- mem_ack  in  1  bus completion; may be asserted in the same cycle as mem_req
- mem_rdata  in  32  read data, valid when mem_ack=1 on a read
- out_valid  out  1  result bundle valid
- out_ready  in  1  writeback accepts the bundle
- icode_o  out  8  forwarded icode
- valE_o  out  32  forwarded valE
- valM_o  out  32  memory read data (0 for non-read ops)
- stat_o  out  4  status: AOK=1, HLT=2, ADR=3

Behaviour:

Reset (rst=0 at a clk edge):
- State is IDLE.
- Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, icode_o=NOP, valE_o=0, valM_o=0, stat_o=AOK.
- in_ready=1 once reset is released.

in_ready:
- in_ready = (state==IDLE), decoded from registered state.
- An accept occurs only when in_valid && in_ready at a clk edge.

Op decode:
- Writes: RMMOVL addr=valE, data=valA; PUSHL addr=valE, data=valA; CALL addr=valE, data=valA.
- Reads: MRMOVL addr=valE; POPL addr=valA; RET addr=valA.
- All other icodes, including unknown ones, do no memory access.

FSM has three states, IDLE, ACCESS and DONE.

IDLE:
- On accept, latch icode and valE into the output registers.
- Memory op: register mem_req=1 with mem_we/mem_addr/mem_wdata, then go to ACCESS.
- Non-memory op: set valM_o=0 and go to DONE.

ACCESS:
- mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
- On ack: mem_req goes to 0 the next cycle, valM_o=mem_rdata for reads (0 for writes), then go to DONE.
- There is no timeout.

DONE:
- out_valid=1; the bundle is held stable until out_ready=1.
- Then out_valid=0 and return to IDLE.
- out_valid deasserts and in_ready asserts in the same cycle.

stat_o:
- HLT when icode=HALT; otherwise AOK.
- HALT takes the non-memory path.

Latency:
- Non-memory op: out_valid rises 1 cycle after accept.
- Memory op with ack in the first request cycle: out_valid rises 2 cycles after accept; each extra ack-wait cycle adds 1.

Boundaries:
- mem_ack outside ACCESS is ignored.
- in_valid while not in IDLE is ignored; upstream must hold its bundle.
- out_ready=1 outside DONE has no effect.
- Reset during ACCESS: mem_req=0 on the next edge and the transaction is abandoned; a late ack is ignored.
- Address uses the low ADDR_W bits with no wrap logic; the bus sees the truncated value.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- When defined, a memory op whose address satisfies either condition below issues no bus request and goes IDLE->DONE directly with stat_o=ADR and valM_o=0:
  - address >= MEM_BYTES−3;
  - address[1:0] != 0.
- When undefined, every memory op goes to the bus and stat_o is never ADR.

Decomposition:
- Add to the shared defines.v:
  - icode constants RMMOVL, MRMOVL, CALL, RET, PUSHL, POPL, HALT, NOP;
  - stat codes AOK/HLT/ADR;
  - FSM state encodings for IDLE/ACCESS/DONE.
- Optional sub-module mem_addr_chk, instantiated only under MEM_ADDR_CHECK_EN: combinational address/alignment check that outputs an adr_err flag.

Test Plan:
- Non-memory op: accept OPL, valE=0x15, out_ready=1 → out_valid 1 cycle later; icode_o=OPL, valE_o=0x15, valM_o=0, stat_o=AOK; no mem_req.
- Load: MRMOVL, valE=0x100; mem_ack delayed 3 cycles, rdata=0xDEADBEEF → mem_addr=0x100 and mem_we=0 held stable across the wait; valM_o=0xDEADBEEF; in_ready=0 throughout.
- Store/CALL:
  - RMMOVL valE=0x200, valA=0x55, same-cycle ack → mem_we=1, wdata=0x55, out_valid 2 cycles after accept.
  - CALL valE=0x3FC, valA=0x40 → write of 0x40 to 0x3FC.
- RET/POPL: valA=0x3FC read, ack with rdata=0x40 → mem_addr=0x3FC, valM_o=0x40.
- Backpressure: DONE with out_ready=0 for 4 cycles → bundle stable and in_ready=0; out_ready=1 → IDLE next cycle.
- Reset during ACCESS: rst=0 mid-wait → mem_req=0 next edge; a late ack is ignored. With MEM_ADDR_CHECK_EN, MRMOVL valE=0x102 → no mem_req, stat_o=ADR.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the Y86 memory stage.
//   - Y86 icode constants (8-bit instruction byte)
//   - stat codes presented to writeback
//   - FSM state encoding
//   - op decode helper mapping an icode to its data-memory access
package mem_stage_pkg;

  localparam logic [7:0] I_HALT   = 8'h00;
  localparam logic [7:0] I_NOP    = 8'h01;
  localparam logic [7:0] I_RRMOVL = 8'h02;
  localparam logic [7:0] I_IRMOVL = 8'h03;
  localparam logic [7:0] I_RMMOVL = 8'h04;
  localparam logic [7:0] I_MRMOVL = 8'h05;
  localparam logic [7:0] I_OPL    = 8'h06;
  localparam logic [7:0] I_JXX    = 8'h07;
  localparam logic [7:0] I_CALL   = 8'h08;
  localparam logic [7:0] I_RET    = 8'h09;
  localparam logic [7:0] I_PUSHL  = 8'h0A;
  localparam logic [7:0] I_POPL   = 8'h0B;

  localparam logic [3:0] S_AOK = 4'd1;
  localparam logic [3:0] S_HLT = 4'd2;
  localparam logic [3:0] S_ADR = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic is_mem;    // icode touches data memory
    logic is_write;  // store (valA is the write data)
    logic use_vala;  // address comes from valA instead of valE
  } op_t;

  // Stack pops (POPL/RET) read at the old stack pointer carried in valA;
  // every other access uses the ALU result valE as the address.
  function automatic op_t decode_op(input logic [7:0] icode);
    op_t op;
    op = '0;
    case (icode)
      I_RMMOVL, I_PUSHL, I_CALL: begin
        op.is_mem   = 1'b1;
        op.is_write = 1'b1;
      end
      I_MRMOVL: begin
        op.is_mem = 1'b1;
      end
      I_POPL, I_RET: begin
        op.is_mem   = 1'b1;
        op.use_vala = 1'b1;
      end
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_addr_chk.sv
// mem_addr_chk: combinational data-memory address check, used by mem_stage
// only when MEM_ADDR_CHECK_EN is defined.
// Ports:
//   addr     in   ADDR_W  byte address of the pending access
//   adr_err  out  1       address would run past the last full word of
//                         memory, or is not word aligned
module mem_addr_chk #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              adr_err
);

  // A 4-byte access starting at MEM_BYTES-3 or above would cross the end.
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES - 3);

  assign adr_err = (addr >= LIMIT) || (addr[1:0] != 2'b00);

endmodule

// File: rtl/mem_stage.sv
// mem_stage: Y86 memory stage. Takes the execute bundle (icode/valA/valE),
// performs at most one data-memory read or write over a req/ack bus, and
// hands icode/valE/valM/stat to writeback through a valid/ready handshake.
// Upstream is stalled (in_ready=0) from accept until the bundle leaves.
//
// Optional build macro: MEM_ADDR_CHECK_EN -- reject out-of-range or
// misaligned addresses with stat ADR instead of issuing a bus request.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        execute-side handshake
//   icode_i, valA_i, valE_i  execute bundle
//   mem_req/we/addr/wdata    data bus request (registered, held until ack)
//   mem_ack, mem_rdata       data bus completion and read data
//   out_valid/out_ready      writeback-side handshake
//   icode_o, valE_o, valM_o, stat_o  result bundle
//
// state  | meaning
// IDLE   | ready for a new bundle
// ACCESS | bus request outstanding, waiting for mem_ack
// DONE   | result bundle valid, waiting for out_ready
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        icode_i,
  input  logic [31:0]       valA_i,
  input  logic [31:0]       valE_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        icode_o,
  output logic [31:0]       valE_o,
  output logic [31:0]       valM_o,
  output logic [3:0]        stat_o
);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        icode_q, icode_d;
  logic [31:0]       vale_q, vale_d;
  logic [31:0]       valm_q, valm_d;
  logic [3:0]        stat_q, stat_d;

  op_t               op;
  logic [ADDR_W-1:0] sel_addr;
  logic              adr_err;

  assign op       = decode_op(icode_i);
  // Only the low ADDR_W bits reach the bus; there is no wrap handling.
  assign sel_addr = op.use_vala ? valA_i[ADDR_W-1:0] : valE_i[ADDR_W-1:0];

`ifdef MEM_ADDR_CHECK_EN
  mem_addr_chk #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES)
  ) u_addr_chk (
    .addr   (sel_addr),
    .adr_err(adr_err)
  );
`else
  assign adr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      icode_q <= I_NOP;
      vale_q  <= '0;
      valm_q  <= '0;
      stat_q  <= S_AOK;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      icode_q <= icode_d;
      vale_q  <= vale_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    icode_d = icode_q;
    vale_d  = vale_q;
    valm_d  = valm_q;
    stat_d  = stat_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          icode_d = icode_i;
          vale_d  = valE_i;
          valm_d  = '0;
          stat_d  = (icode_i == I_HALT) ? S_HLT : S_AOK;
          if (op.is_mem && !adr_err) begin
            req_d   = 1'b1;
            we_d    = op.is_write;
            addr_d  = sel_addr;
            wdata_d = op.is_write ? valA_i : 32'h0;
            state_d = ST_ACCESS;
          end else begin
            if (op.is_mem) stat_d = S_ADR;
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          // Drop the whole request so the bus returns to its idle values.
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          valm_d  = we_q ? 32'h0 : mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign icode_o   = icode_q;
  assign valE_o    = vale_q;
  assign valM_o    = valm_q;
  assign stat_o    = stat_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  icode_i;
  logic [31:0] valA_i;
  logic [31:0] valE_i;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  icode_o;
  logic [31:0] valE_o;
  logic [31:0] valM_o;
  logic [3:0]  stat_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.ADDR_W(32), .MEM_BYTES(4096)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .icode_i  (icode_i),
    .valA_i   (valA_i),
    .valE_i   (valE_i),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .icode_o  (icode_o),
    .valE_o   (valE_o),
    .valM_o   (valM_o),
    .stat_o   (stat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] ic, input logic [31:0] a, input logic [31:0] e);
    in_valid = 1'b1;
    icode_i  = ic;
    valA_i   = a;
    valE_i   = e;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; icode_i = 8'h0; valA_i = 0; valE_i = 0;
    mem_ack = 1'b0; mem_rdata = 0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_icode",     32'(icode_o),   32'h01);
    chk("rst_valE",      valE_o,         32'd0);
    chk("rst_valM",      valM_o,         32'd0);
    chk("rst_stat",      32'(stat_o),    32'd1);
    rst = 1'b1;
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Non-memory op: OPL
    out_ready = 1'b1;
    send(8'h06, 32'h0, 32'h15);
    tick();
    in_valid = 1'b0;
    chk("opl_out_valid", 32'(out_valid), 32'd1);
    chk("opl_icode",     32'(icode_o),   32'h06);
    chk("opl_valE",      valE_o,         32'h15);
    chk("opl_valM",      valM_o,         32'h0);
    chk("opl_stat",      32'(stat_o),    32'd1);
    chk("opl_no_req",    32'(mem_req),   32'd0);
    chk("opl_in_ready",  32'(in_ready),  32'd0);
    tick();
    chk("opl_idle_ov",   32'(out_valid), 32'd0);
    chk("opl_idle_ir",   32'(in_ready),  32'd1);

    // Load with a 3-cycle ack delay; a competing bundle is offered meanwhile
    send(8'h05, 32'h0, 32'h100);
    tick();
    send(8'h06, 32'h999, 32'h777);
    chk("ld_req",   32'(mem_req), 32'd1);
    chk("ld_we",    32'(mem_we),  32'd0);
    chk("ld_addr",  mem_addr,     32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_wait_req",  32'(mem_req),   32'd1);
      chk("ld_wait_we",   32'(mem_we),    32'd0);
      chk("ld_wait_addr", mem_addr,       32'h100);
      chk("ld_wait_ir",   32'(in_ready),  32'd0);
      chk("ld_wait_ov",   32'(out_valid), 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0; in_valid = 1'b0;
    chk("ld_out_valid", 32'(out_valid), 32'd1);
    chk("ld_valM",      valM_o,         32'hDEADBEEF);
    chk("ld_icode",     32'(icode_o),   32'h05);
    chk("ld_valE",      valE_o,         32'h100);
    chk("ld_req_drop",  32'(mem_req),   32'd0);
    chk("ld_in_ready",  32'(in_ready),  32'd0);
    tick();

    // Store with same-cycle ack: out_valid two cycles after accept
    send(8'h04, 32'h55, 32'h200);
    mem_ack = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("st_req",   32'(mem_req),   32'd1);
    chk("st_we",    32'(mem_we),    32'd1);
    chk("st_addr",  mem_addr,       32'h200);
    chk("st_wdata", mem_wdata,      32'h55);
    chk("st_ov0",   32'(out_valid), 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("st_ov1",   32'(out_valid), 32'd1);
    chk("st_valM",  valM_o,         32'h0);
    chk("st_req0",  32'(mem_req),   32'd0);
    tick();

    // CALL: write valA to valE
    send(8'h08, 32'h40, 32'h3FC);
    tick();
    in_valid = 1'b0;
    chk("call_we",    32'(mem_we),  32'd1);
    chk("call_addr",  mem_addr,     32'h3FC);
    chk("call_wdata", mem_wdata,    32'h40);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("call_ov",    32'(out_valid), 32'd1);
    chk("call_icode", 32'(icode_o),   32'h08);
    chk("call_valE",  valE_o,         32'h3FC);
    tick();

    // RET: read at valA, then hold the bundle under backpressure
    send(8'h09, 32'h3FC, 32'h400);
    tick();
    in_valid = 1'b0;
    chk("ret_addr", mem_addr,     32'h3FC);
    chk("ret_we",   32'(mem_we),  32'd0);
    out_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h40;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ov",    32'(out_valid), 32'd1);
      chk("bp_valM",  valM_o,         32'h40);
      chk("bp_icode", 32'(icode_o),   32'h09);
      chk("bp_valE",  valE_o,         32'h400);
      chk("bp_stat",  32'(stat_o),    32'd1);
      chk("bp_ir",    32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_ov", 32'(out_valid), 32'd0);
    chk("bp_rel_ir", 32'(in_ready),  32'd1);

    // POPL: read at valA, not valE
    send(8'h0B, 32'h500, 32'h504);
    tick();
    in_valid = 1'b0;
    chk("pop_addr", mem_addr, 32'h500);
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0;
    chk("pop_valM", valM_o, 32'h1234);
    tick();

    // HALT: non-memory, stat HLT
    send(8'h00, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("hlt_req",  32'(mem_req),   32'd0);
    chk("hlt_ov",   32'(out_valid), 32'd1);
    chk("hlt_stat", 32'(stat_o),    32'd2);
    tick();

    // Unknown icode: no access
    send(8'hF3, 32'h100, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("unk_req",  32'(mem_req),   32'd0);
    chk("unk_ov",   32'(out_valid), 32'd1);
    chk("unk_stat", 32'(stat_o),    32'd1);
    tick();

    // Reset during ACCESS; a late ack afterwards is ignored
    send(8'h05, 32'h0, 32'h104);
    tick();
    in_valid = 1'b0;
    chk("ra_req1", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("ra_req0", 32'(mem_req),   32'd0);
    chk("ra_ov",   32'(out_valid), 32'd0);
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD;
    tick();
    mem_ack = 1'b0;
    chk("ra_late_req", 32'(mem_req),   32'd0);
    chk("ra_late_ov",  32'(out_valid), 32'd0);
    chk("ra_late_ir",  32'(in_ready),  32'd1);
    chk("ra_late_vm",  valM_o,         32'd0);

    // Misaligned load
    send(8'h05, 32'h0, 32'h102);
    tick();
    in_valid = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    chk("adr_req",  32'(mem_req),   32'd0);
    chk("adr_ov",   32'(out_valid), 32'd1);
    chk("adr_stat", 32'(stat_o),    32'd3);
    chk("adr_valM", valM_o,         32'd0);
    tick();
`else
    chk("adr_req",  32'(mem_req),  32'd1);
    chk("adr_addr", mem_addr,      32'h102);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    chk("adr_stat", 32'(stat_o),   32'd1);
    chk("adr_valM", valM_o,        32'h77);
    tick();
`endif
    chk("end_ir", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
